// File: rtl/fir4sum_decoder.sv
// rtl/fir4sum_decoder.sv - inverse 4-tap moving-sum decoder with range check and sticky fault
module fir4sum_decoder #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           in_valid,
    input  logic [W+1:0]   in_sum,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           fault,
    output logic [7:0]     err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t         state_q;

    // Stage 1: registered input sample
    logic           s1_valid_q;
    logic [W+1:0]   s1_sum_q;

    // Recursion history: last accepted sum and the last four reconstructed samples
    logic [W+1:0]   y_prev_q;
    logic [W-1:0]   h1_q, h2_q, h3_q, h4_q;

    // Stage 2: registered outputs
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic           fault_q;
    logic [7:0]     err_cnt_q;

    logic signed [W+3:0] diff;
    logic signed [W+3:0] recon;
    logic                in_range;
    logic                process_s2;
    logic                good_s2;
    logic                bad_s2;

    // Reconstruct x[k] = y[k] - y[k-1] + x[k-4] and classify it against the W-bit range
    always_comb begin
        diff       = $signed({2'b00, s1_sum_q}) - $signed({2'b00, y_prev_q});
        recon      = diff + $signed({4'b0000, h4_q});
        in_range   = (recon[W+3:W] == 4'b0000);
        process_s2 = s1_valid_q && (state_q != ST_FAULT);
        good_s2    = process_s2 && in_range;
        bad_s2     = process_s2 && !in_range;
    end

    // Pipeline, history and FSM; a fault blocks the sample entering stage 1 on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            y_prev_q    <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            h3_q        <= '0;
            h4_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            fault_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            s1_valid_q  <= 1'b0;
            y_prev_q    <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            h3_q        <= '0;
            h4_q        <= '0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            s1_valid_q  <= in_valid && (state_q != ST_FAULT) && !bad_s2;
            if (in_valid) begin
                s1_sum_q <= in_sum;
            end
            out_valid_q <= good_s2;
            if (good_s2) begin
                out_data_q <= recon[W-1:0];
                y_prev_q   <= s1_sum_q;
                h1_q       <= recon[W-1:0];
                h2_q       <= h1_q;
                h3_q       <= h2_q;
                h4_q       <= h3_q;
                if (state_q == ST_IDLE) begin
                    state_q <= ST_RUN;
                end
            end
            if (bad_s2) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign fault     = fault_q;
    assign err_cnt   = err_cnt_q;

endmodule
